// File: rtl/msrv_pkg.sv
// rtl/msrv_pkg.sv - shared immediate-type encodings, occupancy states and XLEN legality
package msrv_pkg;

  localparam logic [3:0] IMM_I      = 4'd0;
  localparam logic [3:0] IMM_I_ALT1 = 4'd1;
  localparam logic [3:0] IMM_S      = 4'd2;
  localparam logic [3:0] IMM_B      = 4'd3;
  localparam logic [3:0] IMM_U      = 4'd4;
  localparam logic [3:0] IMM_J      = 4'd5;
  localparam logic [3:0] IMM_CSR    = 4'd6;
  localparam logic [3:0] IMM_I_ALT7 = 4'd7;
  localparam logic [3:0] IMM_SHAMT  = 4'd8;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  function automatic bit is_legal_xlen(input int xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/msrv_imm_gen_pipe_if.sv
// rtl/msrv_imm_gen_pipe_if.sv - upstream/downstream handshake bundle for the immediate pipe
interface msrv_imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush_in;
  logic             valid_in;
  logic             ready_out;
  logic [24:0]      instr_in;
  logic [3:0]       imm_type_in;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic             ready_in;
  logic [XLEN-1:0]  imm_out;
  logic [TAG_W-1:0] tag_out;
  logic             imm_illegal_out;

  modport slave (
    input  flush_in, valid_in, instr_in, imm_type_in, tag_in, ready_in,
    output ready_out, valid_out, imm_out, tag_out, imm_illegal_out
  );

  modport master (
    output flush_in, valid_in, instr_in, imm_type_in, tag_in, ready_in,
    input  ready_out, valid_out, imm_out, tag_out, imm_illegal_out
  );
endinterface

// File: rtl/msrv_imm_decode.sv
// rtl/msrv_imm_decode.sv - combinational immediate extraction from instruction bits [31:7]
module msrv_imm_decode
  import msrv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  logic [3:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Renumbered so slices read exactly like the ISA bit positions.
  logic [31:7] ins;
  logic        s;

  assign ins = instr;
  assign s   = ins[31];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I, IMM_I_ALT1, IMM_I_ALT7:
        imm = {{(XLEN-11){s}}, ins[30:20]};
      IMM_S:
        imm = {{(XLEN-11){s}}, ins[30:25], ins[11:7]};
      IMM_B:
        imm = {{(XLEN-12){s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:
        imm = {{(XLEN-31){s}}, ins[30:12], 12'h000};
      IMM_J:
        imm = {{(XLEN-20){s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_CSR:
        imm = {{(XLEN-5){1'b0}}, ins[19:15]};
      IMM_SHAMT:
        imm = {{(XLEN-6){1'b0}}, ((XLEN == XLEN_64) ? ins[25] : 1'b0), ins[24:20]};
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/msrv_imm_gen_pipe.sv
// rtl/msrv_imm_gen_pipe.sv - immediate generator with registered output and one-entry skid
module msrv_imm_gen_pipe
  import msrv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  msrv_imm_gen_pipe_if.slave   bus
);

  if (!is_legal_xlen(XLEN)) begin : g_bad_xlen
    $error("msrv_imm_gen_pipe: XLEN must be 32 or 64");
  end

  occ_state_t       state, state_nxt;
  logic [XLEN-1:0]  dec_imm, out_imm, skid_imm;
  logic             dec_ill, out_ill, skid_ill;
  logic [TAG_W-1:0] out_tag, skid_tag;
  logic             push, pop, out_valid, in_ready;
  logic             load_out, load_skid, shift_skid;

  msrv_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (bus.instr_in),
    .imm_type (bus.imm_type_in),
    .imm      (dec_imm),
    .illegal  (dec_ill)
  );

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL) && !rst_in && !bus.flush_in;
  assign push      = bus.valid_in && in_ready;
  assign pop       = out_valid && bus.ready_in;

  assign bus.ready_out       = in_ready;
  assign bus.valid_out       = out_valid;
  assign bus.imm_out         = out_imm;
  assign bus.tag_out         = out_tag;
  assign bus.imm_illegal_out = out_ill;

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      ST_EMPTY: if (push) begin
        state_nxt = ST_ONE;
        load_out  = 1'b1;
      end
      ST_ONE: begin
        if (push && pop) begin
          load_out = 1'b1;
        end else if (push) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        state_nxt  = ST_ONE;
        shift_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush overrides everything; the data registers are simply left stale.
    if (bus.flush_in) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_EMPTY;
      out_imm  <= '0;
      out_tag  <= '0;
      out_ill  <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_ill <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out_imm <= dec_imm;
        out_tag <= bus.tag_in;
        out_ill <= dec_ill;
      end else if (shift_skid) begin
        out_imm <= skid_imm;
        out_tag <= skid_tag;
        out_ill <= skid_ill;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_tag <= bus.tag_in;
        skid_ill <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_msrv_imm_gen_pipe.sv
// tb/tb_msrv_imm_gen_pipe.sv - directed self-checking bench for 32- and 64-bit immediate pipes
module tb_msrv_imm_gen_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  msrv_imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  msrv_imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  msrv_imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b32)
  );

  msrv_imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] ty,
                       input logic [4:0] tg);
    b32.valid_in = v;  b32.instr_in = ins[31:7]; b32.imm_type_in = ty; b32.tag_in = tg;
    b64.valid_in = v;  b64.instr_in = ins[31:7]; b64.imm_type_in = ty; b64.tag_in = tg;
  endtask

  task automatic set_ready(input logic r);
    b32.ready_in = r;
    b64.ready_in = r;
  endtask

  task automatic set_flush(input logic f);
    b32.flush_in = f;
    b64.flush_in = f;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                         input logic [4:0] etag, input logic eill);
    chk({tag, "_valid"}, {63'd0, b32.valid_out}, 64'd1);
    chk({tag, "_imm32"}, {32'd0, b32.imm_out}, {32'd0, e32});
    chk({tag, "_imm64"}, b64.imm_out, e64);
    chk({tag, "_tag"}, {59'd0, b32.tag_out}, {59'd0, etag});
    chk({tag, "_ill"}, {63'd0, b32.imm_illegal_out}, {63'd0, eill});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_flush(1'b0);
    set_ready(1'b0);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    step();
    step();

    // Reset state
    chk("rst_valid", {63'd0, b32.valid_out}, 64'd0);
    chk("rst_imm", {32'd0, b32.imm_out}, 64'd0);
    chk("rst_tag", {59'd0, b32.tag_out}, 64'd0);
    chk("rst_ill", {63'd0, b32.imm_illegal_out}, 64'd0);
    chk("rst_ready", {63'd0, b32.ready_out}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, b32.ready_out}, 64'd1);

    // Streaming decode of each type, ready_in held high
    set_ready(1'b1);
    drive(1'b1, 32'hFFF00093, 4'd0, 5'd3);
    step();
    chk_out("i_neg1", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd3, 1'b0);
    drive(1'b1, 32'hFE000EE3, 4'd3, 5'd4);
    step();
    chk_out("b_neg4", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5'd4, 1'b0);
    drive(1'b1, 32'h123450B7, 4'd4, 5'd5);
    step();
    chk_out("u", 32'h12345000, 64'h0000000012345000, 5'd5, 1'b0);
    drive(1'b1, 32'h000F8073, 4'd6, 5'd6);
    step();
    chk_out("csr", 32'h0000001F, 64'h000000000000001F, 5'd6, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 4'd12, 5'd7);
    step();
    chk_out("illegal12", 32'h0, 64'h0, 5'd7, 1'b1);
    drive(1'b1, 32'hFE112E23, 4'd2, 5'd8);
    step();
    chk_out("s_neg4", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5'd8, 1'b0);
    drive(1'b1, 32'hFFDFF0EF, 4'd5, 5'd9);
    step();
    chk_out("j_neg4", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 5'd9, 1'b0);
    drive(1'b1, 32'h03F0D093, 4'd8, 5'd10);
    step();
    chk_out("shamt", 32'h0000001F, 64'h000000000000003F, 5'd10, 1'b0);
    drive(1'b1, 32'h7FF00093, 4'd7, 5'd11);
    step();
    chk_out("i7_max", 32'h000007FF, 64'h00000000000007FF, 5'd11, 1'b0);
    drive(1'b1, 32'h80000093, 4'd1, 5'd12);
    step();
    chk_out("i1_min", 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 5'd12, 1'b0);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    step();
    chk("drain_empty", {63'd0, b32.valid_out}, 64'd0);

    // Backpressure: fill both entries, stall a third, then drain in order
    set_ready(1'b0);
    drive(1'b1, 32'h00100093, 4'd0, 5'd1);
    step();
    chk("bp_one_ready", {63'd0, b32.ready_out}, 64'd1);
    drive(1'b1, 32'h00200093, 4'd0, 5'd2);
    step();
    chk("bp_full_ready", {63'd0, b32.ready_out}, 64'd0);
    chk_out("bp_head", 32'd1, 64'd1, 5'd1, 1'b0);
    drive(1'b1, 32'h00300093, 4'd0, 5'd3);
    step();
    chk("bp_stall_ready", {63'd0, b32.ready_out}, 64'd0);
    chk_out("bp_stable", 32'd1, 64'd1, 5'd1, 1'b0);
    set_ready(1'b1);
    #1;
    chk("bp_full_rdy_in", {63'd0, b32.ready_out}, 64'd0);
    step();
    chk_out("bp_second", 32'd2, 64'd2, 5'd2, 1'b0);
    chk("bp_one_again", {63'd0, b32.ready_out}, 64'd1);
    step();
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    chk_out("bp_third", 32'd3, 64'd3, 5'd3, 1'b0);
    step();
    chk("bp_drained", {63'd0, b32.valid_out}, 64'd0);

    // Flush while FULL with a simultaneous offer
    set_ready(1'b0);
    drive(1'b1, 32'h00A00093, 4'd0, 5'd20);
    step();
    drive(1'b1, 32'h00B00093, 4'd0, 5'd21);
    step();
    drive(1'b1, 32'h00C00093, 4'd0, 5'd22);
    set_flush(1'b1);
    #1;
    chk("fl_ready_low", {63'd0, b32.ready_out}, 64'd0);
    step();
    set_flush(1'b0);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    #1;
    chk("fl_valid", {63'd0, b32.valid_out}, 64'd0);
    chk("fl_ready", {63'd0, b32.ready_out}, 64'd1);
    set_ready(1'b1);
    step();
    chk("fl_nothing", {63'd0, b32.valid_out}, 64'd0);

    // Reset while FULL, then resume
    set_ready(1'b0);
    drive(1'b1, 32'h01400093, 4'd0, 5'd24);
    step();
    drive(1'b1, 32'h01500093, 4'd0, 5'd25);
    step();
    chk("pre_rst_full", {63'd0, b32.ready_out}, 64'd0);
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    rst = 1'b1;
    step();
    chk("mrst_valid", {63'd0, b32.valid_out}, 64'd0);
    chk("mrst_imm", {32'd0, b32.imm_out}, 64'd0);
    chk("mrst_imm64", b64.imm_out, 64'd0);
    chk("mrst_tag", {59'd0, b32.tag_out}, 64'd0);
    chk("mrst_ready", {63'd0, b32.ready_out}, 64'd0);
    rst = 1'b0;
    #1;
    chk("mrst_release_ready", {63'd0, b32.ready_out}, 64'd1);
    set_ready(1'b1);
    drive(1'b1, 32'h01600093, 4'd0, 5'd26);
    step();
    drive(1'b0, 32'h0, 4'd0, 5'd0);
    chk_out("mrst_resume", 32'h16, 64'h16, 5'd26, 1'b0);
    step();
    chk("final_empty", {63'd0, b32.valid_out}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv_imm_gen_pipe.md
MSRV_IMM_GEN_PIPE -- requirements
Module: msrv_imm_gen_pipe

Interface
REQ-001 Parameters, one per line (name, default, meaning); all ports follow, one per line (name, direction, width, meaning), clock and reset first:
  XLEN  32  immediate width; legal values 32 and 64 only
  TAG_W  5  width of sideband tag carried with each immediate (e.g. rd index)
  clk_in  input  1  single clock; all state updates on rising edge
  rst_in  input  1  reset, synchronous, active-high
  flush_in  input  1  discard all held entries
  valid_in  input  1  upstream offers an instruction
  ready_out  output  1  block can accept this cycle
  instr_in  input  25  instruction bits [31:7]
  imm_type_in  input  4  immediate type select
  tag_in  input  TAG_W  sideband tag
  valid_out  output  1  immediate available
  ready_in  input  1  downstream accepts this cycle
  imm_out  output  XLEN  generated immediate
  tag_out  output  TAG_W  tag matching imm_out
  imm_illegal_out  output  1  imm_type_in was not a defined type
REQ-002 The reset is synchronous and active-high on the single clock clk_in; reset port rst_in.

Function
REQ-003 Type encoding, all signed forms sign-extended from instr bit 31 to XLEN: 0,1,7 = I {instr[31:20]}; 2 = S {instr[31:25],instr[11:7]}; 3 = B {instr[31],instr[7],instr[30:25],instr[11:8],0}; 4 = U {instr[31:12],12'h000}; 5 = J {instr[31],instr[19:12],instr[20],instr[30:21],0}; 6 = CSR zimm zero-extended instr[19:15]; 8 = shamt zero-extended instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32).
REQ-004 Types 9-15 produce imm = 0 and imm_illegal_out = 1 for that entry; all defined types produce imm_illegal_out = 0.
REQ-005 Transfer in occurs when valid_in && ready_out; transfer out occurs when valid_out && ready_in.
REQ-006 Immediate is computed at input and registered; latency is exactly one cycle from accept to valid_out when the block was empty or draining.
REQ-007 Storage is a 2-entry skid: output register plus one skid register; occupancy FSM states EMPTY, ONE, FULL.
REQ-008 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (output reloaded); ONE+in only -> FULL (new entry to skid); ONE+out only -> EMPTY; FULL+out -> ONE (skid moves to output, same cycle); all other combinations hold state.
REQ-009 ready_out = (state != FULL) && !rst_in && !flush_in; a FULL block never accepts, even if ready_in is high that cycle.
REQ-010 valid_out = (state != EMPTY); imm_out/tag_out/imm_illegal_out remain stable while valid_out && !ready_in.
REQ-011 Entries leave strictly in acceptance order; no entry is dropped or duplicated except by flush or reset.
REQ-012 flush_in forces state EMPTY next cycle; flush wins over a simultaneous accept or pop; data registers need not clear.

Reset
REQ-013 While rst_in is high at a clock edge: state = EMPTY, valid_out = 0, imm_out = 0, tag_out = 0, imm_illegal_out = 0; ready_out is 0 during reset and 1 in the first cycle after release.
REQ-014 Reset mid-operation discards held entries; no transfer in or out is counted in the reset cycle.

Structure
REQ-015 Shared package msrv_pkg holds the imm-type encodings (4-bit constants), FSM state encoding, and legal XLEN values.
REQ-016 Decode is one combinational sub-module msrv_imm_decode (instr, type -> imm, illegal) instantiated once at the input; the skid/FSM is in the top.
REQ-017 An elaboration-time check rejects XLEN other than 32 or 64.

Verification
REQ-018 XLEN=32, type 0, instr 32'hFFF00093 ([31:7]), ready_in=1 -> next cycle valid_out=1, imm_out=32'hFFFFFFFF; XLEN=64 -> 64'hFFFFFFFFFFFFFFFF.
REQ-019 Type 3, instr 32'hFE000EE3 -> imm_out=32'hFFFFFFFC; type 4, instr 32'h123450B7, XLEN=64 -> 64'h0000000012345000.
REQ-020 Backpressure: ready_in=0, push tags 1,2 -> ready_out=0 after second accept; third valid_in stalls; raise ready_in -> tags 1,2,3 emerge in order, one per cycle.
REQ-021 Type 6 with instr[19:15]=5'h1F -> imm_out=32'h1F; type 12 -> imm_out=0, imm_illegal_out=1.
REQ-022 State FULL, assert flush_in with valid_in=1 -> next cycle valid_out=0, ready_out=1, flushed/incoming entries never appear.
REQ-023 Assert rst_in while FULL -> next cycle all outputs 0, ready_out=0; release -> ready_out=1 and a new accept appears one cycle later.
